// File: rtl/fetch_pkg.sv
// fetch_pkg: entry record and constants shared by the fetch/prefetch path
package fetch_pkg;
    localparam int ILEN = 32;
    localparam int PC_STEP = 4;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] pcplus4;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with flush and occupancy count; head is read combinationally
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: credit-limited instruction prefetcher with redirect flush and stale-response dropping
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRvalid,
    input  logic [XLEN-1:0] ImemRdata,
    output logic            ValidD,
    input  logic            ReadyD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = 16;
    logic [XLEN-1:0] pcf, tag_pc;
    logic [CW-1:0] iq_count, tag_count;
    logic [DW-1:0] drop_cnt, drop_sum;
    logic [3*XLEN-1:0] head;
    logic grant, accept, pop;
    // the tag queue holds exactly the live (non-dropped) outstanding requests
    assign ImemAddr = pcf;
    assign ImemReq  = rst && !PCSrcE && (int'(iq_count) + int'(tag_count) < DEPTH);
    assign grant    = ImemReq && ImemGnt;
    assign accept   = ImemRvalid && drop_cnt == '0 && !PCSrcE;
    assign ValidD   = iq_count != '0;
    assign pop      = ValidD && ReadyD && !PCSrcE;
    assign {InstrD, PCD, PCPlus4D} = ValidD ? head : '0;
    assign drop_sum = drop_cnt + DW'(tag_count);
    sync_fifo #(.WIDTH(3*XLEN), .DEPTH(DEPTH)) u_iq (
        .clk(clk), .rst(rst), .flush(PCSrcE), .push(accept), .pop(pop),
        .wdata({ImemRdata, tag_pc, tag_pc + XLEN'(PC_STEP)}), .rdata(head), .count(iq_count)
    );
    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
        .clk(clk), .rst(rst), .flush(PCSrcE), .push(grant), .pop(accept),
        .wdata(pcf), .rdata(tag_pc), .count(tag_count)
    );
    // on redirect every request still in flight after this cycle becomes stale
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcf      <= RESET_PC;
            drop_cnt <= '0;
        end else if (PCSrcE) begin
            pcf      <= PCTargetE & ~XLEN'(3);
            drop_cnt <= drop_sum - DW'(ImemRvalid && drop_sum != '0);
        end else begin
            if (grant) pcf <= pcf + XLEN'(PC_STEP);
            if (ImemRvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end
endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 32, PC/instruction width.
- DEPTH, 4, instruction-queue entries, power of two, >=2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, all state on rising edge.
- rst, in, 1, synchronous active-low reset.
- PCSrcE, in, 1, execute-stage redirect request.
- PCTargetE, in, XLEN, redirect target.
- ImemReq, out, 1, fetch request valid.
- ImemAddr, out, XLEN, fetch address.
- ImemGnt, in, 1, request accepted this cycle.
- ImemRvalid, in, 1, in-order read data valid, >=1 cycle after grant.
- ImemRdata, in, XLEN, instruction word.
- ValidD, out, 1, queue head valid to decode.
- ReadyD, in, 1, decode accepts head (deasserted = stall).
- InstrD, out, XLEN, head instruction.
- PCD, out, XLEN, head PC.
- PCPlus4D, out, XLEN, head PC+4.
REQ-003 Clock SHALL be clk; reset SHALL be rst, synchronous, active-low; no other clock or asynchronous reset.

Function
REQ-004 Fetch PC register PCF SHALL drive ImemAddr; PCF advances by 4 (mod 2^XLEN, wrap from all-ones-minus-3 to 0) on each ImemReq&&ImemGnt.
REQ-005 Request hold: ImemReq SHALL stay asserted with stable ImemAddr until granted, except when withdrawn by redirect or reset.
REQ-006 Credits: ImemReq SHALL assert only when count + live_outstanding < DEPTH, where live_outstanding = granted-not-returned minus drop_cnt; the queue therefore never overflows.
REQ-007 Each non-dropped ImemRvalid SHALL write {ImemRdata, PC, PC+4} into the queue tail, PC taken from a DEPTH-entry in-order PC tag queue recorded at grant.
REQ-008 Latency: an entry written on cycle N SHALL be visible on ValidD/InstrD at cycle N+1; no same-cycle bypass.
REQ-009 Handshake: head SHALL pop on ValidD&&ReadyD; InstrD/PCD/PCPlus4D SHALL hold stable while ValidD&&!ReadyD.
REQ-010 Simultaneous push and pop SHALL leave count unchanged; push when full is impossible by REQ-006; pop when empty SHALL not occur (ValidD=0).
REQ-011 Redirect (PCSrcE=1, cycle R): at R+1 queue empty (ValidD=0), PCF = {PCTargetE[XLEN-1:2],2'b00}; ImemReq SHALL be 0 in cycle R; response arriving in R SHALL be discarded.
REQ-012 drop_cnt at R+1 SHALL equal outstanding requests after R; each subsequent ImemRvalid while drop_cnt>0 SHALL be discarded and decrement drop_cnt.
REQ-013 Redirect SHALL override simultaneous pop, push, grant and ReadyD; back-to-back redirects SHALL each take effect, the last target winning.
REQ-014 Requests to the new target MAY issue from R+1 regardless of drop_cnt; in-order return guarantees correct ordering.

Reset
REQ-015 While rst=0 at a rising edge: PCF=RESET_PC, count=0, outstanding=0, drop_cnt=0, ImemReq=0, ValidD=0, InstrD=0, PCD=0, PCPlus4D=0.
REQ-016 Reset mid-operation SHALL abandon in-flight requests; the memory side is reset by the same rst, so no drop tracking survives reset.
REQ-017 First ImemReq SHALL assert the first cycle after rst deasserts.

Structure
REQ-018 Shared package fetch_pkg SHALL hold the queue entry record {instr, pc, pcplus4}, the PC_STEP=4 constant and the NOP encoding 32'h0000_0013.
REQ-019 Queue SHALL be one sub-module sync_fifo (parameterised width/depth, synchronous flush, count output), instanced twice: instruction queue and PC tag queue.

Verification
REQ-020 Directed scenarios (fixed-1-cycle memory model unless stated):
- Reset release, ReadyD=1: ImemAddr 0,4,8,...; ValidD first high 2 cycles after release with PCD=0, PCPlus4D=4.
- ReadyD=0 for 10 cycles, DEPTH=4: exactly 4 grants then ImemReq=0; ValidD and head (PCD=0) held stable throughout.
- 3-cycle latency memory, 3 outstanding, PCSrcE=1 with PCTargetE=32'h0000_0103: next PCF=0x100, 3 stale responses dropped, first ValidD has PCD=0x100.
- PCF=32'hFFFF_FFFC granted: next ImemAddr=0, PCPlus4D of that entry=0.
- Random ImemGnt/ReadyD for 10k cycles: PCD sequence strictly +4 between redirects, never loses or duplicates an instruction.
- rst=0 asserted with queue full and 2 outstanding: next cycle all outputs at REQ-015 values; restart at RESET_PC.
